// File: rtl/pipe_stage_register.sv
// pipe_stage_register
// Generic pipeline stage register with a valid/ready handshake and a
// one-entry skid buffer. The payload is split into control bits, which are
// cleared on flush/reset and gated by valid, and plain data bits.
// In_Ready and Out_Valid come straight from flops, so there is no
// combinational path from Out_Ready to In_Ready.
// A saturating counter records the cycles spent stalled by downstream.
//
// Optional build macro: PIPE_DEBUG_PATTERN_EN
//   When defined, a flush fills head/skid data with DEBUG_PATTERN so that
//   flushed slots stand out in waveforms. When undefined, a flush leaves the
//   data registers holding their previous contents.

module pipe_stage_register #(
    parameter int          CTRL_W        = 4,
    parameter int          DATA_W        = 128,
    parameter int          CNT_W         = 16,
    parameter logic [31:0] DEBUG_PATTERN = 32'h2A2A_2A2A
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              Flush,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [CTRL_W-1:0] In_Ctrl,
    input  logic [DATA_W-1:0] In_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [CTRL_W-1:0] Out_Ctrl,
    output logic [DATA_W-1:0] Out_Data,
    output logic [CNT_W-1:0]  Stall_Count
);

`ifdef PIPE_DEBUG_PATTERN_EN
    localparam bit DEBUG_EN = 1'b1;
`else
    localparam bit DEBUG_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    // Replicate the 32-bit debug word across the data width, truncating the top.
    function automatic logic [DATA_W-1:0] debug_fill(input logic [31:0] pat);
        logic [DATA_W-1:0] res;
        for (int i = 0; i < DATA_W; i++) begin
            res[i] = pat[i % 32];
        end
        return res;
    endfunction

    localparam logic [DATA_W-1:0] FLUSH_FILL = debug_fill(DEBUG_PATTERN);

    state_t            state_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [CTRL_W-1:0] head_ctrl_r;
    logic [DATA_W-1:0] head_data_r;
    logic [CTRL_W-1:0] skid_ctrl_r;
    logic [DATA_W-1:0] skid_data_r;
    logic [CNT_W-1:0]  stall_cnt_r;

    logic              in_fire_s;
    logic              out_fire_s;
    logic              stall_s;
    logic [DATA_W-1:0] flush_head_data_s;
    logic [DATA_W-1:0] flush_skid_data_s;

    assign in_fire_s  = In_Valid & in_ready_r;
    assign out_fire_s = out_valid_r & Out_Ready;
    assign stall_s    = out_valid_r & ~Out_Ready;

    assign flush_head_data_s = DEBUG_EN ? FLUSH_FILL : head_data_r;
    assign flush_skid_data_s = DEBUG_EN ? FLUSH_FILL : skid_data_r;

    assign In_Ready    = in_ready_r;
    assign Out_Valid   = out_valid_r;
    assign Out_Ctrl    = head_ctrl_r & {CTRL_W{out_valid_r}};
    assign Out_Data    = head_data_r;
    assign Stall_Count = stall_cnt_r;

    // Handshake FSM with head/skid storage; reset beats flush beats transfers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            head_ctrl_r <= {CTRL_W{1'b0}};
            head_data_r <= {DATA_W{1'b0}};
            skid_ctrl_r <= {CTRL_W{1'b0}};
            skid_data_r <= {DATA_W{1'b0}};
        end else if (Flush) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            head_ctrl_r <= {CTRL_W{1'b0}};
            head_data_r <= flush_head_data_s;
            skid_ctrl_r <= {CTRL_W{1'b0}};
            skid_data_r <= flush_skid_data_s;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        head_ctrl_r <= In_Ctrl;
                        head_data_r <= In_Data;
                        state_r     <= ST_FULL;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (in_fire_s && out_fire_s) begin
                        head_ctrl_r <= In_Ctrl;
                        head_data_r <= In_Data;
                    end else if (in_fire_s) begin
                        // Downstream stalled: park the new entry in the skid slot.
                        skid_ctrl_r <= In_Ctrl;
                        skid_data_r <= In_Data;
                        state_r     <= ST_SKID;
                        in_ready_r  <= 1'b0;
                    end else if (out_fire_s) begin
                        state_r     <= ST_EMPTY;
                        out_valid_r <= 1'b0;
                    end
                end
                ST_SKID: begin
                    if (out_fire_s) begin
                        head_ctrl_r <= skid_ctrl_r;
                        head_data_r <= skid_data_r;
                        state_r     <= ST_FULL;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    head_ctrl_r <= {CTRL_W{1'b0}};
                    skid_ctrl_r <= {CTRL_W{1'b0}};
                end
            endcase
        end
    end

    // Saturating stall counter; only reset clears it, flush leaves it alone.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

endmodule
